// File: rtl/div_sequencer.sv
// Multi-cycle RISC-V style integer divider (DIV/DIVU/REM/REMU).
// Restoring division, one quotient bit per cycle, with sign fix-up and a special-case shortcut.
module div_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

   localparam logic [XLEN-1:0] One    = XLEN'(1);
   localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [4:0]      LastIt = 5'(XLEN - 1);

   state_e          state_q;
   logic [1:0]      op_q;
   logic [XLEN-1:0] quo_q;     // holds the dividend until CALC shifts quotient bits into it
   logic [XLEN-1:0] dvs_q;
   logic [XLEN:0]   rem_q;
   logic            qneg_q;
   logic            rneg_q;
   logic [4:0]      cnt_q;
   logic [XLEN-1:0] result_q;
   logic            done_q;
   logic            busy_q;

   logic            signed_op;
   logic            dvd_neg;
   logic            dvs_neg;
   logic            div_zero;
   logic            overflow;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;
   logic            borrow;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   always_comb begin
      signed_op = ~op_q[0];
      dvd_neg   = signed_op & quo_q[XLEN-1];
      dvs_neg   = signed_op & dvs_q[XLEN-1];
      div_zero  = (dvs_q == '0);
      overflow  = signed_op && (quo_q == IntMin) && (dvs_q == '1);
      rem_sh    = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      diff      = {1'b0, rem_sh} - {2'b00, dvs_q};
      borrow    = diff[XLEN+1];
      quo_fix   = qneg_q ? (~quo_q + One) : quo_q;
      rem_fix   = rneg_q ? (~rem_q[XLEN-1:0] + One) : rem_q[XLEN-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         op_q     <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start_i) begin
                     op_q    <= op_i;
                     quo_q   <= dividend_i;
                     dvs_q   <= divisor_i;
                     busy_q  <= 1'b1;
                     state_q <= StPrep;
                  end
               end
               StPrep: begin
                  if (div_zero) begin
                     result_q <= op_q[1] ? quo_q : '1;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else if (overflow) begin
                     result_q <= op_q[1] ? '0 : IntMin;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     quo_q   <= dvd_neg ? (~quo_q + One) : quo_q;
                     dvs_q   <= dvs_neg ? (~dvs_q + One) : dvs_q;
                     rem_q   <= '0;
                     qneg_q  <= dvd_neg ^ dvs_neg;
                     rneg_q  <= dvd_neg;
                     cnt_q   <= '0;
                     state_q <= StCalc;
                  end
               end
               StCalc: begin
                  quo_q <= {quo_q[XLEN-2:0], ~borrow};
                  rem_q <= borrow ? rem_sh : diff[XLEN:0];
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == LastIt) begin
                     state_q <= StFix;
                  end
               end
               StFix: begin
                  result_q <= op_q[1] ? rem_fix : quo_fix;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
               end
               StDone: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized bench for div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

   div_sequencer #(.XLEN(32)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .op_i      (op_i),
      .dividend_i(dividend_i),
      .divisor_i (divisor_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V division semantics using plain integer arithmetic.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int sa, sb;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         sa = int'(a);
         sb = int'(b);
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic int lat_of(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Called just after the accepting edge; done must rise exactly lat edges later.
   task automatic expect_done(input int lat, input logic [31:0] exp, input string tag);
      logic early = 1'b0;
      for (int k = 1; k < lat; k++) begin
         @(posedge clk); #1;
         if (done_o !== 1'b0 || busy_o !== 1'b1) early = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "_early"}, 32'(early), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_result"}, result_o, exp);
   endtask

   task automatic after_done(input logic [31:0] exp, input string tag);
      @(posedge clk); #1;
      chk({tag, "_idle"}, {30'd0, busy_o, done_o}, 32'd0);
      chk({tag, "_hold"}, result_o, exp);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] exp, input string tag);
      start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
      @(posedge clk); #1;
      start_i = 1'b0;
      expect_done(lat, exp, tag);
      after_done(exp, tag);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic        seen;

      #1 rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {busy_o, done_o, 30'd0}, 32'd0);
      chk("reset_result", result_o, 32'd0);
      @(negedge clk) rst_ni = 1'b1;

      run_op(OpDivu, 32'd100, 32'd7, 34, 32'd14, "divu_100_7");
      run_op(OpRemu, 32'd100, 32'd7, 34, 32'd2, "remu_100_7");
      run_op(OpDiv, -32'sd7, 32'd2, 34, 32'hFFFF_FFFD, "div_m7_2");
      run_op(OpRem, -32'sd7, 32'd2, 34, 32'hFFFF_FFFF, "rem_m7_2");
      run_op(OpRem, 32'd7, -32'sd2, 34, 32'd1, "rem_7_m2");
      run_op(OpDiv, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "div_5_0");
      run_op(OpRemu, 32'd5, 32'd0, 1, 32'd5, "remu_5_0");
      run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
      run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem_ovf");

      // Flush during CALC iteration 10: result must keep the previous value.
      run_op(OpDivu, 32'd1000, 32'd9, 34, 32'd111, "pre_flush");
      start_i = 1'b1; op_i = OpDivu; dividend_i = 32'd12345; divisor_i = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (11) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("flush_idle", {30'd0, busy_o, done_o}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_o) seen = 1'b1;
      end
      chk("flush_no_done", 32'(seen), 32'd0);
      chk("flush_hold", result_o, 32'd111);
      run_op(OpDivu, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, "divu_max_1");

      // Flush wins over start in IDLE.
      start_i = 1'b1; flush_i = 1'b1; op_i = OpDivu; dividend_i = 32'd9; divisor_i = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      chk("flush_start_idle", {30'd0, busy_o, done_o}, 32'd0);
      @(posedge clk); #1;
      chk("flush_start_stay", {30'd0, busy_o, done_o}, 32'd0);

      // start held high with changing operands: ignored while busy, accepted after DONE.
      start_i = 1'b1; op_i = OpDivu; dividend_i = 32'd1000; divisor_i = 32'd3;
      @(posedge clk); #1;
      op_i = OpRemu; dividend_i = 32'd1000; divisor_i = 32'd7;
      expect_done(34, 32'd333, "b2b_first");
      @(posedge clk); #1;
      chk("b2b_gap_idle", 32'(busy_o), 32'd0);
      @(posedge clk); #1;
      chk("b2b_accept", 32'(busy_o), 32'd1);
      start_i = 1'b0;
      expect_done(34, 32'd6, "b2b_second");
      after_done(32'd6, "b2b_second");

      // Reset mid-operation aborts asynchronously; first edge afterwards accepts start.
      start_i = 1'b1; op_i = OpDiv; dividend_i = 32'd77; divisor_i = 32'd5;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_ctl", {30'd0, busy_o, done_o}, 32'd0);
      chk("async_rst_result", result_o, 32'd0);
      @(negedge clk) rst_ni = 1'b1;
      run_op(OpRem, -32'sd77, 32'd5, 34, 32'hFFFF_FFFE, "post_reset");

      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = -32'($urandom_range(1, 15));
            4: a = 32'($urandom_range(0, 99));
            default: ;
         endcase
         run_op(op, a, b, lat_of(op, a, b), model(op, a, b), $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
